// File: rtl/vdp_port_pkg.sv
// vdp_port_pkg: shared constants and types for the VDP CPU port controller.
package vdp_port_pkg;

  // VRAM address width (128 KB) and palette size.
  localparam int VRAM_AW     = 17;
  localparam int PAL_ENTRIES = 16;

  // CPU port codes (A[1:0]).
  localparam logic [1:0] PORT_DATA = 2'd0;
  localparam logic [1:0] PORT_CTRL = 2'd1;
  localparam logic [1:0] PORT_PAL  = 2'd2;
  localparam logic [1:0] PORT_IND  = 2'd3;

  // Register numbers shadowed by the port controller.
  localparam logic [5:0] R14 = 6'd14;
  localparam logic [5:0] R15 = 6'd15;
  localparam logic [5:0] R16 = 6'd16;
  localparam logic [5:0] R17 = 6'd17;

  // VRAM request state.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } xfer_state_e;

endpackage

// File: rtl/vdp_vram_xfer.sv
// vdp_vram_xfer: one outstanding VRAM request plus a one-entry pending slot,
// sticky overrun flag and the prefetch read buffer.
module vdp_vram_xfer
  import vdp_port_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               acc_valid,
  input  logic               acc_wr,
  input  logic [VRAM_AW-1:0] acc_addr,
  input  logic [7:0]         acc_wdata,
  output logic               acc_taken,
  output logic               vram_req,
  output logic               vram_wr,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic               vram_ack,
  input  logic [7:0]         vram_rdata,
  output logic [7:0]         read_buf,
  output logic               overrun
);

  xfer_state_e        state_reg, state_next;
  logic               issue_pend, issue_acc, park_acc, drop_acc;
  logic               pend_valid_reg, pend_wr_reg;
  logic [VRAM_AW-1:0] pend_addr_reg, out_addr_reg;
  logic [7:0]         pend_wdata_reg, out_wdata_reg, read_buf_reg;
  logic               out_wr_reg, overrun_reg;

  // Request state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next state and routing of a new access: issue, park in the slot, or drop.
  // A parked entry always goes out first, on the idle cycle after its ack.
  always_comb begin
    state_next = state_reg;
    issue_pend = 1'b0;
    issue_acc  = 1'b0;
    park_acc   = 1'b0;
    drop_acc   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pend_valid_reg) begin
          issue_pend = 1'b1;
          state_next = BUSY;
        end else if (acc_valid) begin
          issue_acc  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: if (vram_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (acc_valid && !issue_acc) begin
      if (pend_valid_reg) drop_acc = 1'b1;
      else                park_acc = 1'b1;
    end
  end

  // Request registers, pending slot, read buffer and overrun flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_valid_reg <= 1'b0;
      pend_wr_reg    <= 1'b0;
      pend_addr_reg  <= '0;
      pend_wdata_reg <= 8'h00;
      out_wr_reg     <= 1'b0;
      out_addr_reg   <= '0;
      out_wdata_reg  <= 8'h00;
      read_buf_reg   <= 8'h00;
      overrun_reg    <= 1'b0;
    end else begin
      if (issue_pend) begin
        out_wr_reg    <= pend_wr_reg;
        out_addr_reg  <= pend_addr_reg;
        out_wdata_reg <= pend_wdata_reg;
      end else if (issue_acc) begin
        out_wr_reg    <= acc_wr;
        out_addr_reg  <= acc_addr;
        out_wdata_reg <= acc_wdata;
      end
      if (issue_pend) begin
        pend_valid_reg <= 1'b0;
      end else if (park_acc) begin
        pend_valid_reg <= 1'b1;
        pend_wr_reg    <= acc_wr;
        pend_addr_reg  <= acc_addr;
        pend_wdata_reg <= acc_wdata;
      end
      // Acks outside a transaction (e.g. straggling after reset) are ignored.
      if (state_reg == BUSY && vram_ack && !out_wr_reg) read_buf_reg <= vram_rdata;
      if (drop_acc) overrun_reg <= 1'b1;
    end
  end

  assign acc_taken  = acc_valid & ~drop_acc;
  assign vram_req   = (state_reg == BUSY);
  assign vram_wr    = out_wr_reg;
  assign vram_addr  = out_addr_reg;
  assign vram_wdata = out_wdata_reg;
  assign read_buf   = read_buf_reg;
  assign overrun    = overrun_reg;

endmodule

// File: rtl/vdp_port_ctrl.sv
// vdp_port_ctrl: V9938/V9958 CPU port protocol for ports $98-$9B.
// Optional macro VDP_INDIRECT_REG_EN enables indirect register writes on port 3.
module vdp_port_ctrl
  import vdp_port_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               CpuReq,
  input  logic               CpuWrt,
  input  logic [1:0]         CpuAdr,
  input  logic [7:0]         CpuDbo,
  output logic [7:0]         CpuDbi,
  input  logic [7:0]         status_data,
  output logic [3:0]         status_sel,
  output logic               status_rd,
  output logic               reg_wr_en,
  output logic [5:0]         reg_wr_addr,
  output logic [7:0]         reg_wr_data,
  output logic               vram_req,
  output logic               vram_wr,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic               vram_ack,
  input  logic [7:0]         vram_rdata,
  output logic               pal_wr_en,
  output logic [3:0]         pal_addr,
  output logic [8:0]         pal_data,
  output logic               overrun
);

  localparam logic [3:0] PAL_LAST = 4'(PAL_ENTRIES - 1);

  logic               ctrl_flag_reg, pal_flag_reg, status_rd_reg;
  logic [7:0]         ctrl_latch_reg;
  logic [2:0]         pal_r_reg, pal_b_reg;
  logic [2:0]         r14_hi_reg;   // R#14[2:0]: pointer bits 16:14
  logic [3:0]         r15_sel_reg;  // R#15[3:0]: status register select
  logic [3:0]         r16_idx_reg;  // R#16[3:0]: palette index
  logic [13:0]        ptr_lo_reg;
  logic               reg_wr_en_reg, reg_wr_en_next;
  logic [5:0]         reg_wr_addr_reg, reg_wr_addr_next;
  logic [7:0]         reg_wr_data_reg, reg_wr_data_next;
  logic               pal_wr_en_reg;
  logic [3:0]         pal_addr_reg;
  logic [8:0]         pal_data_reg;
  logic               ctrl_wr, ctrl_rd, pal_wr, ctrl_second, ptr_set, prefetch_set, data_acc;
  logic               acc_valid, acc_wr, acc_taken;
  logic [VRAM_AW-1:0] ptr, ptr_inc, ptr_load, acc_addr;
  logic [7:0]         read_buf;
  logic [3:0]         pal_idx_inc;

  assign ctrl_wr      = CpuReq & CpuWrt & (CpuAdr == PORT_CTRL);
  assign ctrl_rd      = CpuReq & ~CpuWrt & (CpuAdr == PORT_CTRL);
  assign pal_wr       = CpuReq & CpuWrt & (CpuAdr == PORT_PAL);
  assign ctrl_second  = ctrl_wr & ctrl_flag_reg;
  assign ptr_set      = ctrl_second & ~CpuDbo[7];
  assign prefetch_set = ptr_set & ~CpuDbo[6];
  assign data_acc     = CpuReq & (CpuAdr == PORT_DATA);

  // The pointer's top bits live in the R#14 shadow, so carries land there.
  assign ptr      = {r14_hi_reg, ptr_lo_reg};
  assign ptr_inc  = ptr + 17'd1;
  assign ptr_load = {r14_hi_reg, CpuDbo[5:0], ctrl_latch_reg};

  assign acc_valid = data_acc | prefetch_set;
  assign acc_wr    = data_acc & CpuWrt;
  assign acc_addr  = prefetch_set ? ptr_load : ptr;

  assign pal_idx_inc = (r16_idx_reg == PAL_LAST) ? 4'd0 : r16_idx_reg + 4'd1;

`ifdef VDP_INDIRECT_REG_EN
  logic       ind_wr;
  logic       r17_stop_reg;  // R#17 b7: inhibit auto-increment
  logic [5:0] r17_idx_reg;   // R#17[5:0]: indirect target register
  assign ind_wr = CpuReq & CpuWrt & (CpuAdr == PORT_IND);
`endif

  // Register-write request from port 1 (second byte, b7=1) or port 3.
  always_comb begin
    reg_wr_en_next   = 1'b0;
    reg_wr_addr_next = reg_wr_addr_reg;
    reg_wr_data_next = reg_wr_data_reg;
    if (ctrl_second && CpuDbo[7]) begin
      reg_wr_en_next   = 1'b1;
      reg_wr_addr_next = CpuDbo[5:0];
      reg_wr_data_next = ctrl_latch_reg;
    end
`ifdef VDP_INDIRECT_REG_EN
    if (ind_wr && r17_idx_reg != R17) begin
      reg_wr_en_next   = 1'b1;
      reg_wr_addr_next = r17_idx_reg;
      reg_wr_data_next = CpuDbo;
    end
`endif
  end

  // Port protocol state: byte latches, pointer, shadows and output pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_flag_reg   <= 1'b0;
      ctrl_latch_reg  <= 8'h00;
      pal_flag_reg    <= 1'b0;
      pal_r_reg       <= 3'd0;
      pal_b_reg       <= 3'd0;
      r14_hi_reg      <= 3'd0;
      r15_sel_reg     <= 4'd0;
      r16_idx_reg     <= 4'd0;
      ptr_lo_reg      <= 14'd0;
      reg_wr_en_reg   <= 1'b0;
      reg_wr_addr_reg <= 6'd0;
      reg_wr_data_reg <= 8'h00;
      pal_wr_en_reg   <= 1'b0;
      pal_addr_reg    <= 4'd0;
      pal_data_reg    <= 9'd0;
      status_rd_reg   <= 1'b0;
`ifdef VDP_INDIRECT_REG_EN
      r17_stop_reg    <= 1'b0;
      r17_idx_reg     <= 6'd0;
`endif
    end else begin
      reg_wr_en_reg   <= reg_wr_en_next;
      reg_wr_addr_reg <= reg_wr_addr_next;
      reg_wr_data_reg <= reg_wr_data_next;
      status_rd_reg   <= ctrl_rd;
      pal_wr_en_reg   <= 1'b0;

      // Control byte pairing; a status read resynchronises the pair.
      if (ctrl_rd) begin
        ctrl_flag_reg <= 1'b0;
      end else if (ctrl_wr) begin
        if (!ctrl_flag_reg) begin
          ctrl_latch_reg <= CpuDbo;
          ctrl_flag_reg  <= 1'b1;
        end else begin
          ctrl_flag_reg  <= 1'b0;
        end
      end

      // Pointer load, or advance on every accepted port-0 access.
      if (ptr_set) begin
        ptr_lo_reg <= ptr_load[13:0];
      end else if (data_acc && acc_taken) begin
        ptr_lo_reg <= ptr_inc[13:0];
        r14_hi_reg <= ptr_inc[16:14];
      end

      if (reg_wr_en_next) begin
        case (reg_wr_addr_next)
          R14: r14_hi_reg  <= reg_wr_data_next[2:0];
          R15: r15_sel_reg <= reg_wr_data_next[3:0];
          R16: r16_idx_reg <= reg_wr_data_next[3:0];
`ifdef VDP_INDIRECT_REG_EN
          R17: begin
            r17_stop_reg <= reg_wr_data_next[7];
            r17_idx_reg  <= reg_wr_data_next[5:0];
          end
`endif
          default: ;
        endcase
      end

      // Palette: first byte holds R/B, second byte supplies G and commits.
      if (pal_wr) begin
        if (!pal_flag_reg) begin
          pal_r_reg    <= CpuDbo[6:4];
          pal_b_reg    <= CpuDbo[2:0];
          pal_flag_reg <= 1'b1;
        end else begin
          pal_flag_reg  <= 1'b0;
          pal_wr_en_reg <= 1'b1;
          pal_addr_reg  <= r16_idx_reg;
          pal_data_reg  <= {pal_r_reg, pal_b_reg, CpuDbo[2:0]};
          r16_idx_reg   <= pal_idx_inc;
        end
      end

`ifdef VDP_INDIRECT_REG_EN
      if (ind_wr && !r17_stop_reg) r17_idx_reg <= r17_idx_reg + 6'd1;
`endif
    end
  end

  // Read-data mux back to the CPU front end.
  always_comb begin
    CpuDbi = 8'hFF;
    case (CpuAdr)
      PORT_DATA: CpuDbi = read_buf;
      PORT_CTRL: CpuDbi = status_data;
      default:   CpuDbi = 8'hFF;
    endcase
  end

  vdp_vram_xfer u_xfer (
    .clk        (clk),
    .reset_n    (reset_n),
    .acc_valid  (acc_valid),
    .acc_wr     (acc_wr),
    .acc_addr   (acc_addr),
    .acc_wdata  (CpuDbo),
    .acc_taken  (acc_taken),
    .vram_req   (vram_req),
    .vram_wr    (vram_wr),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_ack   (vram_ack),
    .vram_rdata (vram_rdata),
    .read_buf   (read_buf),
    .overrun    (overrun)
  );

  assign status_sel  = r15_sel_reg;
  assign status_rd   = status_rd_reg;
  assign reg_wr_en   = reg_wr_en_reg;
  assign reg_wr_addr = reg_wr_addr_reg;
  assign reg_wr_data = reg_wr_data_reg;
  assign pal_wr_en   = pal_wr_en_reg;
  assign pal_addr    = pal_addr_reg;
  assign pal_data    = pal_data_reg;

endmodule
